sram_mem_controller: RTL and testbench
======================================

SRAM_MEM_CONTROLLER -- requirements
Module: sram_mem_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, cycles per SRAM half-word phase (legal 1..15).
REQ-002 SHALL have ports:
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous, active-low reset
  rd_en  input  1  memory read request from MEM stage
  wr_en  input  1  memory write request from MEM stage
  address  input  32  byte address, word aligned
  write_data  input  32  store data
  read_data  output  32  load result, registered
  ready  output  1  high = no access pending or access completing; pipeline freeze = ~ready
  sram_addr  output  18  SRAM half-word address
  sram_wdata  output  16  SRAM write data
  sram_rdata  input  16  SRAM read data
  sram_ce_n  output  1  chip enable, active low
  sram_oe_n  output  1  output enable, active low
  sram_we_n  output  1  write enable, active low

Function
REQ-003 SHALL implement FSM states IDLE, LOW, HIGH, DONE, plus a 4-bit phase counter.
REQ-004 In IDLE, rd_en|wr_en high SHALL accept the request: latch address[18:2], write_data, and op (write if wr_en, else read); go to LOW, counter=0.
REQ-005 rd_en and wr_en both high SHALL be executed as a write; read_data is unchanged.
REQ-006 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles; counter increments per cycle, clears on phase change.
REQ-007 LOW -> HIGH, HIGH -> DONE on the last phase cycle; DONE -> IDLE unconditionally after one cycle.
REQ-008 ready SHALL be combinational from state and request: 1 in DONE, 1 in IDLE with no request, 0 otherwise, including the IDLE acceptance cycle.
REQ-009 Latency: request first seen in IDLE at cycle t -> ready high at cycle t+2*WAIT_CYCLES+1 (DONE).
REQ-010 sram_addr SHALL be {latched addr[18:2], 0} in LOW and {latched addr[18:2], 1} in HIGH; 0 elsewhere.
REQ-011 sram_ce_n SHALL be 0 in LOW/HIGH, 1 elsewhere.
REQ-012 Write: sram_we_n=0 in LOW/HIGH; sram_wdata = data[15:0] in LOW, data[31:16] in HIGH; sram_oe_n=1.
REQ-013 Read: sram_oe_n=0 in LOW/HIGH; sram_we_n=1; sram_rdata registered on last LOW cycle into read_data[15:0], on last HIGH cycle into read_data[31:16].
REQ-014 In IDLE/DONE, sram_we_n=sram_oe_n=1 and sram_wdata=0.
REQ-015 read_data SHALL hold its value until the next read overwrites it; valid from the DONE cycle onward.
REQ-016 Inputs changing or requests deasserting after acceptance SHALL not affect the in-flight access; it completes with latched values.
REQ-017 A request held through DONE SHALL not be re-accepted in DONE; the next request is evaluated in IDLE, giving back-to-back accesses one IDLE cycle apart.
REQ-018 address[1:0] and address[31:19] SHALL be ignored.

Reset
REQ-019 rst_n low SHALL immediately, regardless of clk, force state IDLE, counter 0, read_data 0, latched registers 0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_addr=0, sram_wdata=0.
REQ-020 Reset mid-access SHALL abort it with no further SRAM strobes; after release, ready=1 in IDLE with no request.

Verification (WAIT_CYCLES=2 unless stated)
REQ-021 Write 0x12345678 to address 0x08 at t0 -> t0+1..2: sram_addr=0x00004, wdata=0x5678, we_n=0; t0+3..4: sram_addr=0x00005, wdata=0x1234; ready=1 at t0+5 only.
REQ-022 Read address 0x08 with model returning 0x5678/0x1234 -> read_data=0x12345678 at DONE (t0+5); oe_n=0, we_n=1 throughout.
REQ-023 rd_en=wr_en=1 with write_data 0xCAFEBABE -> write strobes issued, read_data keeps its prior value.
REQ-024 Assert rst_n=0 during HIGH of a write -> all strobes high and read_data=0 within the same cycle, ready=1 after release.
REQ-025 Two reads held back to back -> second acceptance one cycle after DONE; ready low except the two DONE cycles.
REQ-026 WAIT_CYCLES=1, write then read -> ready at t0+3 each; read_data equals the written word.

Source files
------------

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Bridges the MEM-stage 32-bit load/store interface to an asynchronous 16-bit
// SRAM. Each access is split into a low half-word phase followed by a high
// half-word phase. Each phase lasts WAIT_CYCLES clocks. The pipeline is frozen
// (ready low) from the cycle the request is accepted until the one-cycle DONE
// state.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rd_en        load request
//   wr_en        store request (wins over rd_en when both are high)
//   address      byte address; only bits [18:2] are used
//   write_data   store data
//   read_data    registered load result; holds until the next load
//   ready        high when idle with no request, or in DONE
//   sram_addr    SRAM half-word address {word index, half select}
//   sram_wdata   SRAM write data
//   sram_rdata   SRAM read data
//   sram_ce_n    SRAM chip enable, active low
//   sram_oe_n    SRAM output enable, active low
//   sram_we_n    SRAM write enable, active low
//   dbg_state_o  current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
//
// Handshake: a request is taken in IDLE when rd_en|wr_en is high. ready is low
// in that same cycle and stays low until DONE. The request inputs are not
// looked at again until the FSM is back in IDLE.
// -----------------------------------------------------------------------------
module sram_mem_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic req;
    logic last_cyc;

    // Byte-lane and out-of-range address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    assign req      = rd_en | wr_en;
    assign last_cyc = (cnt_q == LAST_CNT);

    // Next-state logic, counter, request latch and read capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOW;
                    cnt_d   = 4'd0;
                    addr_d  = address[18:2];
                    data_d  = write_data;
                    wr_d    = wr_en;
                end
            end
            S_LOW: begin
                if (last_cyc) begin
                    state_d = S_HIGH;
                    cnt_d   = 4'd0;
                    // Sample the SRAM at the end of the phase, when it has
                    // had the full WAIT_CYCLES to settle.
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (last_cyc) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // A request still held here is re-evaluated in IDLE.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM strobes and ready decode from the registered state
    always_comb begin
        ready      = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_addr  = 18'd0;
        sram_wdata = 16'd0;
        case (state_q)
            S_IDLE: ready = ~req;
            S_LOW: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = wr_q;
                sram_we_n  = ~wr_q;
                sram_addr  = {addr_q, 1'b0};
                sram_wdata = wr_q ? data_q[15:0] : 16'd0;
            end
            S_HIGH: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = wr_q;
                sram_we_n  = ~wr_q;
                sram_addr  = {addr_q, 1'b1};
                sram_wdata = wr_q ? data_q[31:16] : 16'd0;
            end
            S_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 17'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_data   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Two controllers run side by side: instance 0 uses WAIT_CYCLES=2 and
// instance 1 uses WAIT_CYCLES=1. Each one has its own behavioural half-word
// SRAM. The reference model keeps whole 32-bit words per word index. It
// predicts every cycle of an access from the timing rules: one acceptance
// cycle, W low-half cycles, W high-half cycles, then one DONE cycle.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

    logic        clk;
    logic        rst_n;
    logic        rd_en      [2];
    logic        wr_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] sram_wdata [2];
    logic [15:0] sram_rdata [2];
    logic        ce_n       [2];
    logic        oe_n       [2];
    logic        we_n       [2];
    logic [1:0]  dbg_state  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sram_mem [int];   // half-word SRAM contents, key {inst, addr18}
    logic [31:0] ref_mem  [int];   // reference words, key {inst, word index}
    logic [31:0] exp_rd   [2];     // expected read_data per instance
    logic [31:0] exp_q    [$];     // pending load results

    sram_mem_controller #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]),
        .sram_rdata(sram_rdata[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
        .sram_we_n(we_n[0]), .dbg_state_o(dbg_state[0])
    );

    sram_mem_controller #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]),
        .sram_rdata(sram_rdata[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
        .sram_we_n(we_n[1]), .dbg_state_o(dbg_state[1])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // Untouched SRAM locations hold a fixed pattern derived from their address.
    function automatic logic [15:0] dflt(input logic [17:0] ha);
        return ha[15:0] ^ 16'hA5C3;
    endfunction

    // ---------------- behavioural SRAM ----------------
    // Data is presented at the falling edge for the address driven since the
    // preceding rising edge. Outside a read strobe the bus carries garbage.
    always @(negedge clk) begin
        int key;
        for (int i = 0; i < 2; i++) begin
            key = i * 262144 + int'(sram_addr[i]);
            if (!ce_n[i] && !we_n[i]) sram_mem[key] = sram_wdata[i];
            if (!ce_n[i] && !oe_n[i])
                sram_rdata[i] = sram_mem.exists(key) ? sram_mem[key] : dflt(sram_addr[i]);
            else
                sram_rdata[i] = 16'($urandom);
        end
    end

    // ---------------- reference model ----------------
    function automatic int wait_of(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_read(input int sel, input logic [16:0] idx);
        int key;
        key = sel * 131072 + int'(idx);
        if (ref_mem.exists(key)) return ref_mem[key];
        return {dflt({idx, 1'b1}), dflt({idx, 1'b0})};
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input int sel, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        rd_en[sel]      = rd;
        wr_en[sel]      = wr;
        address[sel]    = a;
        write_data[sel] = d;
    endtask

    task automatic chk_quiet(input int sel, input string ph);
        chk($sformatf("%s_ce_n%0d", ph, sel), 32'(ce_n[sel]), 32'd1);
        chk($sformatf("%s_oe_n%0d", ph, sel), 32'(oe_n[sel]), 32'd1);
        chk($sformatf("%s_we_n%0d", ph, sel), 32'(we_n[sel]), 32'd1);
        chk($sformatf("%s_addr%0d", ph, sel), 32'(sram_addr[sel]), 32'd0);
        chk($sformatf("%s_wdata%0d", ph, sel), 32'(sram_wdata[sel]), 32'd0);
    endtask

    // Called at rising edge + 1. Returns at rising edge + 1 of the next cycle.
    task automatic idle_cycle(input int sel);
        set_req(0, 0, 0, 32'd0, 32'd0);
        set_req(1, 0, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk($sformatf("idle_ready%0d", sel), 32'(ready[sel]), 32'd1);
        chk($sformatf("idle_ce_n%0d", sel), 32'(ce_n[sel]), 32'd1);
        @(posedge clk); #1;
    endtask

    // One full access on instance sel, checked cycle by cycle. When hold is
    // set the request stays asserted through DONE. Otherwise the inputs are
    // dropped and scrambled right after acceptance.
    task automatic run_access(input int sel, input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] d, input bit hold);
        int w;
        bit hi;
        logic [16:0] idx;
        w   = wait_of(sel);
        idx = a[18:2];
        set_req(1 - sel, 0, 0, 32'd0, 32'd0);
        set_req(sel, rd, wr, a, d);
        @(negedge clk);
        chk($sformatf("accept_ready%0d", sel), 32'(ready[sel]), 32'd0);
        chk($sformatf("accept_ce_n%0d", sel), 32'(ce_n[sel]), 32'd1);
        if (wr) ref_mem[sel * 131072 + int'(idx)] = d;
        else    exp_q.push_back(ref_read(sel, idx));
        for (int k = 1; k <= 2 * w; k++) begin
            @(posedge clk); #1;
            if (!hold) set_req(sel, 0, 0, $urandom, $urandom);
            @(negedge clk);
            hi = (k > w);
            chk($sformatf("busy_ready%0d", sel), 32'(ready[sel]), 32'd0);
            chk($sformatf("ce_n%0d", sel), 32'(ce_n[sel]), 32'd0);
            chk($sformatf("sram_addr%0d", sel), 32'(sram_addr[sel]), 32'({idx, hi}));
            chk($sformatf("we_n%0d", sel), 32'(we_n[sel]), 32'(!wr));
            chk($sformatf("oe_n%0d", sel), 32'(oe_n[sel]), 32'(wr));
            if (wr)
                chk($sformatf("wdata%0d", sel), 32'(sram_wdata[sel]),
                    hi ? 32'(d[31:16]) : 32'(d[15:0]));
        end
        @(posedge clk); #1;
        if (!hold) set_req(sel, 0, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk($sformatf("done_ready%0d", sel), 32'(ready[sel]), 32'd1);
        chk_quiet(sel, "done");
        if (!wr) exp_rd[sel] = exp_q.pop_front();
        chk($sformatf("read_data%0d", sel), read_data[sel], exp_rd[sel]);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int sel, op;
        bit hold;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 0, 32'd0, 32'd0);
            exp_rd[i] = 32'd0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
            chk($sformatf("rst_read_data%0d", i), read_data[i], 32'd0);
            chk_quiet(i, "rst");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle(0);

        // Store/load word 0x08, then a store issued with both enables high.
        run_access(0, 0, 1, 32'h0000_0008, 32'h1234_5678, 0);
        idle_cycle(0);
        run_access(0, 1, 0, 32'h0000_0008, 32'd0, 0);
        chk("word08", read_data[0], 32'h1234_5678);
        idle_cycle(0);
        run_access(0, 1, 1, 32'h0000_0010, 32'hCAFE_BABE, 0);
        idle_cycle(0);
        run_access(0, 1, 0, 32'h0000_0010, 32'd0, 0);
        chk("word10", read_data[0], 32'hCAFE_BABE);

        // Held reads: the second one is accepted in the cycle right after DONE.
        run_access(0, 1, 0, 32'hFFF8_0008, 32'd0, 1);
        run_access(0, 1, 0, 32'h0000_0013, 32'd0, 1);
        idle_cycle(0);

        // Single-cycle phases.
        run_access(1, 0, 1, 32'h0000_0040, 32'h89AB_CDEF, 0);
        idle_cycle(1);
        run_access(1, 1, 0, 32'h0000_0040, 32'd0, 0);
        chk("w1_word40", read_data[1], 32'h89AB_CDEF);
        idle_cycle(1);

        // Random mix of loads/stores, address aliasing, holds and gaps.
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 1);
            op   = $urandom_range(0, 2);
            hold = 1'($urandom_range(0, 1));
            a    = $urandom;
            a[18:2] = 17'($urandom_range(0, 31));
            run_access(sel, op != 1, op != 0, a, $urandom, hold);
            if ($urandom_range(0, 2) == 0) idle_cycle(sel);
        end
        idle_cycle(0);

        // Reset in the middle of the high phase of a store.
        run_access(0, 1, 0, 32'h0000_0008, 32'd0, 0);
        set_req(0, 0, 1, 32'h0000_0FA0, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            set_req(0, 0, 0, 32'd0, 32'd0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk_quiet(0, "abort");
        chk("abort_read_data0", read_data[0], 32'd0);
        chk("abort_read_data1", read_data[1], 32'd0);
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 32'(ready[0]), 32'd1);
        chk("post_rst_ready1", 32'(ready[1]), 32'd1);
        chk_quiet(0, "post_rst");
        @(posedge clk); #1;
        run_access(0, 1, 0, 32'h0000_0008, 32'd0, 0);
        idle_cycle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
